tt_sweep_ctrl: RTL and testbench

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

---
 rtl/tt_sweep_pkg.sv | 11 +
 rtl/tt_sweep_ctrl_if.sv | 11 +
 rtl/tt_settle_timer.sv | 26 ++
 rtl/tt_sweep_ctrl.sv | 108 ++++++++++
 tb/tb_tt_sweep_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;
  localparam int NUM_VEC        = 16;
  localparam int SETTLE_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Control link between the sweep FSM (master) and its per-vector settle timer (slave).
// Handshake: load restarts the count for a new sweep; run enables counting; expire is
// high for exactly the cycle in which the current vector has been held long enough.
interface tt_sweep_ctrl_if;
  logic load;
  logic run;
  logic expire;

  modport master (output load, output run, input expire);
  modport slave  (input load, input run, output expire);
endinterface

// File: rtl/tt_settle_timer.sv
// Per-vector settle counter: counts 0..SETTLE while running, flags expire on SETTLE.
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  tt_sweep_ctrl_if.slave tmr
);
  localparam logic [3:0] LIMIT = 4'(SETTLE);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tmr.load) begin
      count <= '0;
    end else if (tmr.run) begin
      count <= (count == LIMIT) ? 4'd0 : count + 4'd1;
    end
  end

  assign tmr.expire = tmr.run && (count == LIMIT);
endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 16 input vectors into a 4-input gate and compares z with a golden table.
// Optional TT_STOP_ON_FAIL_EN: end the sweep on the first mismatching vector.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  output logic        x,
  output logic        y,
  output logic        v,
  output logic        w,
  input  logic        z,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  fail_idx,
  output state_t      state_dbg
);
  state_t     state;
  logic [3:0] idx;
  logic       mism;
  logic       last;
  logic       stop_now;

  tt_sweep_ctrl_if tmr ();

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk (clk),
    .rst (rst),
    .tmr (tmr)
  );

  assign tmr.load = (state == IDLE) && start;
  assign tmr.run  = (state == RUN);

  assign mism = z ^ expected[idx];
  assign last = (idx == 4'(NUM_VEC - 1));
`ifdef TT_STOP_ON_FAIL_EN
  assign stop_now = mism;
`else
  assign stop_now = 1'b0;
`endif

  // idx is the drive register itself, so x/y/v/w come straight off flops.
  assign {x, y, v, w} = idx;
  assign state_dbg    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      fail_idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            idx          <= '0;
            result       <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            fail_idx     <= '0;
          end
        end
        RUN: begin
          if (tmr.expire) begin
            result[idx] <= z;
            if (mism) begin
              if (mismatch_cnt != 5'(NUM_VEC)) mismatch_cnt <= mismatch_cnt + 5'd1;
              if (mismatch_cnt == 5'd0) fail_idx <= idx;
            end
            if (last || stop_now) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              idx   <= '0;
              pass  <= (mismatch_cnt == 5'd0) && !mism;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (SETTLE=2, SETTLE=0) driving AND/OR gate models.
module tb_tt_sweep_ctrl;
  import tt_sweep_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic [4:0]  cnt;
    logic [3:0]  fidx;
    logic        pass;
    logic [9:0]  len;
  } fin_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start    [2];
  logic [15:0] expected [2];
  logic        x [2], y [2], v [2], w [2], z [2];
  logic        busy [2], done [2], pass [2];
  logic [15:0] result [2];
  logic [4:0]  mcnt [2];
  logic [3:0]  fidx [2];
  state_t      st [2];
  logic        fn_and [2];

  int   n_checks = 0;
  int   n_err    = 0;
  int   k [2];
  fin_t m [2];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs and gate models ----------------
  tt_sweep_ctrl #(.SETTLE(2)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .expected(expected[0]),
    .x(x[0]), .y(y[0]), .v(v[0]), .w(w[0]), .z(z[0]),
    .busy(busy[0]), .done(done[0]), .result(result[0]), .pass(pass[0]),
    .mismatch_cnt(mcnt[0]), .fail_idx(fidx[0]), .state_dbg(st[0])
  );

  tt_sweep_ctrl #(.SETTLE(0)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .expected(expected[1]),
    .x(x[1]), .y(y[1]), .v(v[1]), .w(w[1]), .z(z[1]),
    .busy(busy[1]), .done(done[1]), .result(result[1]), .pass(pass[1]),
    .mismatch_cnt(mcnt[1]), .fail_idx(fidx[1]), .state_dbg(st[1])
  );

  assign z[0] = fn_and[0] ? (x[0] & y[0] & v[0] & w[0]) : (x[0] | y[0] | v[0] | w[0]);
  assign z[1] = fn_and[1] ? (x[1] & y[1] & v[1] & w[1]) : (x[1] | y[1] | v[1] | w[1]);

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Final outputs of a sweep, from the gate's truth table and the golden table.
  function automatic fin_t predict(input logic is_and, input logic [15:0] gold, input int s);
    fin_t        f;
    logic [15:0] tt;
    logic [15:0] diff;
    int          first;
    for (int j = 0; j < 16; j++) tt[j] = is_and ? (j == 15) : (j != 0);
    diff  = tt ^ gold;
    first = -1;
    for (int j = 0; j < 16; j++) if (diff[j] && first < 0) first = j;
    f.res  = tt;
    f.cnt  = 5'($countones(diff));
    f.fidx = (first < 0) ? 4'd0 : 4'(first);
    f.pass = (diff == 16'h0);
    f.len  = 10'(16 * (s + 1));
`ifdef TT_STOP_ON_FAIL_EN
    if (first >= 0) begin
      f.res  = tt & 16'((32'd1 << (first + 1)) - 32'd1);
      f.cnt  = 5'd1;
      f.pass = 1'b0;
      f.len  = 10'((first + 1) * (s + 1));
    end
`endif
    return f;
  endfunction

  // ---------------- model: cycles since accepted start ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        k[i] <= -1;
        m[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (k[i] < 0 || k[i] > int'(m[i].len)) begin
          if (start[i]) begin
            k[i] <= 0;
            m[i] <= predict(fn_and[i], expected[i], settle_of(i));
          end else begin
            k[i] <= -1;
          end
        end else begin
          k[i] <= k[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        int   len;
        int   ev;
        logic running;
        logic dn;
        len     = int'(m[i].len);
        running = (k[i] >= 0) && (k[i] < len);
        dn      = (k[i] == len);
        ev      = running ? (k[i] / (settle_of(i) + 1)) : 0;
        chk($sformatf("u%0d_vec", i), int'({x[i], y[i], v[i], w[i]}), ev);
        chk($sformatf("u%0d_busy", i), int'(busy[i]), int'(running));
        chk($sformatf("u%0d_done", i), int'(done[i]), int'(dn));
        chk($sformatf("u%0d_state", i), int'(st[i]),
            running ? int'(RUN) : (dn ? int'(DONE) : int'(IDLE)));
        if (!running) begin
          chk($sformatf("u%0d_result", i), int'(result[i]), int'(m[i].res));
          chk($sformatf("u%0d_pass", i), int'(pass[i]), int'(m[i].pass));
          chk($sformatf("u%0d_mcnt", i), int'(mcnt[i]), int'(m[i].cnt));
          chk($sformatf("u%0d_fidx", i), int'(fidx[i]), int'(m[i].fidx));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int i, input string tag, input int lit_len,
                           input logic [15:0] lit_res, input int lit_pass,
                           input int lit_cnt, input int lit_fidx);
    int c;
    c = 0;
    while (!done[i] && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_latency"}, c, lit_len);
    chk({tag, "_result"}, int'(result[i]), int'(lit_res));
    chk({tag, "_pass"}, int'(pass[i]), lit_pass);
    chk({tag, "_mcnt"}, int'(mcnt[i]), lit_cnt);
    chk({tag, "_fidx"}, int'(fidx[i]), lit_fidx);
    @(negedge clk);
  endtask

  task automatic sweep(input int i, input logic is_and, input logic [15:0] gold,
                       input string tag, input int lit_len, input logic [15:0] lit_res,
                       input int lit_pass, input int lit_cnt, input int lit_fidx);
    @(negedge clk);
    fn_and[i]   = is_and;
    expected[i] = gold;
    start[i]    = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    wait_done(i, tag, lit_len, lit_res, lit_pass, lit_cnt, lit_fidx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; expected[i] = '0; fn_and[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk("reset_vec", int'({x[0], y[0], v[0], w[0]}), 0);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_result", int'(result[0]), 0);
    chk("reset_state", int'(st[0]), int'(IDLE));
    #2 rst = 1'b0;

    sweep(0, 1'b1, 16'h8000, "and_pass", 48, 16'h8000, 1, 0, 0);
`ifdef TT_STOP_ON_FAIL_EN
    sweep(0, 1'b1, 16'h8001, "and_fail0", 3, 16'h0000, 0, 1, 0);
    sweep(1, 1'b0, 16'h0000, "or_fail1", 2, 16'h0002, 0, 1, 1);
    sweep(1, 1'b0, 16'h0001, "or_fail_all", 1, 16'h0000, 0, 1, 0);
`else
    sweep(0, 1'b1, 16'h8001, "and_fail0", 48, 16'h8000, 0, 1, 0);
    sweep(1, 1'b0, 16'h0000, "or_fail1", 16, 16'hFFFE, 0, 15, 1);
    sweep(1, 1'b0, 16'h0001, "or_fail_all", 16, 16'hFFFE, 0, 16, 0);
`endif
    sweep(1, 1'b0, 16'hFFFE, "or_pass_s0", 16, 16'hFFFE, 1, 0, 0);

    // Mid-sweep reset at vector 5, then restart on the first edge after release.
    @(negedge clk);
    fn_and[0] = 1'b0; expected[0] = 16'hFFFE; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_rst_vec", int'({x[0], y[0], v[0], w[0]}), 5);
    chk("pre_rst_result", int'(result[0]), int'(16'h001E));
    #2 rst = 1'b1;
    #1;
    chk("rst_vec", int'({x[0], y[0], v[0], w[0]}), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_result", int'(result[0]), 0);
    chk("rst_pass", int'(pass[0]), 0);
    chk("rst_mcnt", int'(mcnt[0]), 0);
    chk("rst_fidx", int'(fidx[0]), 0);
    chk("rst_state", int'(st[0]), int'(IDLE));
    @(negedge clk);
    fn_and[0] = 1'b1; expected[0] = 16'h8000; start[0] = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, "after_rst", 48, 16'h8000, 1, 0, 0);

    // Start held high: back-to-back sweeps separated by the DONE and IDLE cycles.
    @(negedge clk);
    fn_and[0] = 1'b1; expected[0] = 16'h8000; start[0] = 1'b1;
    @(negedge clk);
    c = 0;
    while (!done[0] && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("held_first_latency", c, 48);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done[0] && c < 400);
    chk("held_gap", c, 50);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
